// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the burst-master state encoding.
// Used by axi_burst_master and axi_burst_perf.
package axi_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_8B     = 3'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

endpackage

// File: rtl/axi_burst_perf.sv
// Burst and stall counters for axi_burst_master.
// Instantiated only when AXI_BURST_MASTER_PERF_EN is defined.
module axi_burst_perf
   import axi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic        wr,
   input  logic        arvalid,
   input  logic        arready,
   input  logic        awvalid,
   input  logic        awready,
   input  logic        wvalid,
   input  logic        wready,
   output logic [31:0] rd_bursts,
   output logic [31:0] wr_bursts,
   output logic [31:0] stall_cyc
);

   logic stall;
   logic fin;

   assign stall = (arvalid & ~arready)
                | (awvalid & ~awready)
                | (wvalid & ~wready);
   assign fin   = (state == S_DONE);

   // count completed bursts by kind and valid-without-ready cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_bursts <= '0;
         wr_bursts <= '0;
         stall_cyc <= '0;
      end else begin
         if (fin && !wr) rd_bursts <= rd_bursts + 32'd1;
         if (fin && wr)  wr_bursts <= wr_bursts + 32'd1;
         stall_cyc <= stall_cyc + {31'd0, stall};
      end
   end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master: one cache request becomes one INCR burst of 64-bit beats.
// Define AXI_BURST_MASTER_PERF_EN to add the perf_* counter outputs.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [DATA_W-1:0]   wbeat_data,
   output logic                wbeat_pop,
   output logic                rbeat_valid,
   output logic [DATA_W-1:0]   rbeat_data,
   output logic                rbeat_last,
   output logic                done,
   output logic                done_err,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   output logic [LEN_W-1:0]    arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   input  logic                rlast,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [LEN_W-1:0]    awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
`ifdef AXI_BURST_MASTER_PERF_EN
   ,
   output logic [31:0]         perf_rd_bursts,
   output logic [31:0]         perf_wr_bursts,
   output logic [31:0]         perf_stall_cyc
`endif
);

   localparam logic [LEN_W:0] ONE = 1;

   logic [2:0]          state;
   logic [ADDR_W-1:0]   addr;
   logic [LEN_W-1:0]    len;
   logic [DATA_W/8-1:0] strb;
   logic                wr;
   logic [LEN_W:0]      cnt;
   logic                err;
   logic                at_last;

   // counter is one bit wider than len so len = 255 never wraps
   assign at_last = (cnt == {1'b0, len});

   // request sequencing, beat counting and sticky error tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         addr  <= '0;
         len   <= '0;
         strb  <= '0;
         wr    <= 1'b0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr  <= req_addr;
                  len   <= req_len;
                  strb  <= req_wstrb;
                  wr    <= req_wr;
                  cnt   <= '0;
                  err   <= 1'b0;
                  state <= req_wr ? S_AW : S_AR;
               end
            end
            S_AR: begin
               if (arready) state <= S_R;
            end
            S_R: begin
               if (rvalid) begin
                  cnt <= cnt + ONE;
                  if (rresp != RESP_OKAY) err <= 1'b1;
                  if (rlast) begin
                     if (!at_last) err <= 1'b1;
                     state <= S_DONE;
                  end else if (cnt >= {1'b0, len}) begin
                     err <= 1'b1;
                  end
               end
            end
            S_AW: begin
               if (awready) state <= S_W;
            end
            S_W: begin
               if (wready) begin
                  cnt <= cnt + ONE;
                  if (at_last) state <= S_B;
               end
            end
            S_B: begin
               if (bvalid) begin
                  if (bresp != RESP_OKAY) err <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = (state == S_IDLE);

   assign araddr      = addr;
   assign arvalid     = (state == S_AR);
   assign arlen       = len;
   assign arsize      = SIZE_8B;
   assign arburst     = BURST_INCR;

   assign rready      = (state == S_R);
   assign rbeat_valid = rready & rvalid;
   assign rbeat_data  = rdata;
   assign rbeat_last  = rready & rvalid & rlast;

   assign awaddr      = addr;
   assign awvalid     = (state == S_AW);
   assign awlen       = len;
   assign awsize      = SIZE_8B;
   assign awburst     = BURST_INCR;

   assign wvalid      = (state == S_W);
   assign wdata       = wbeat_data;
   assign wstrb       = strb;
   assign wlast       = wvalid & at_last;
   assign wbeat_pop   = wvalid & wready;

   assign bready      = (state == S_B);

   assign done        = (state == S_DONE);
   assign done_err    = done & err;

`ifdef AXI_BURST_MASTER_PERF_EN
   axi_burst_perf u_perf (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .wr        (wr),
      .arvalid   (arvalid),
      .arready   (arready),
      .awvalid   (awvalid),
      .awready   (awready),
      .wvalid    (wvalid),
      .wready    (wready),
      .rd_bursts (perf_rd_bursts),
      .wr_bursts (perf_wr_bursts),
      .stall_cyc (perf_stall_cyc)
   );
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: directed bursts plus randomized traffic
// checked against a transaction-level expectation of each burst.
module tb_axi_burst_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [31:0] req_addr;
   logic [7:0]  req_len, req_wstrb;
   logic [63:0] wbeat_data;
   logic        wbeat_pop;
   logic        rbeat_valid, rbeat_last;
   logic [63:0] rbeat_data;
   logic        done, done_err;
   logic [31:0] araddr, awaddr;
   logic        arvalid, arready, awvalid, awready;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst;
   logic [63:0] rdata, wdata;
   logic [1:0]  rresp, bresp;
   logic        rvalid, rlast, rready;
   logic [7:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic        bvalid, bready;
`ifdef AXI_BURST_MASTER_PERF_EN
   logic [31:0] perf_rd_bursts, perf_wr_bursts, perf_stall_cyc;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi_burst_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_len(req_len), .req_wstrb(req_wstrb),
      .wbeat_data(wbeat_data), .wbeat_pop(wbeat_pop),
      .rbeat_valid(rbeat_valid), .rbeat_data(rbeat_data),
      .rbeat_last(rbeat_last), .done(done), .done_err(done_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast),
      .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BURST_MASTER_PERF_EN
      ,
      .perf_rd_bursts(perf_rd_bursts),
      .perf_wr_bursts(perf_wr_bursts),
      .perf_stall_cyc(perf_stall_cyc)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // wait for the single done pulse and its error flag
   task automatic wait_done(input bit exp_err);
      bit seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (i > 0) @(negedge clk);
         if (done) begin
            seen = 1'b1;
            chk("done_err", done_err, exp_err);
         end
      end
      chk("done_seen", seen, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_req_ready", req_ready, 1);
   endtask

   // read burst; slave ends the burst with rlast on beat last_idx
   task automatic do_read(input logic [31:0] a, input int len,
                          input int last_idx, input int ar_dly,
                          input int err_beat, input bit gaps);
      logic [63:0] d;
      logic [1:0]  rr;
      bit          exp_err;
      exp_err = (last_idx != len) || (err_beat >= 0);
      @(negedge clk);
      chk("rd_req_ready", req_ready, 1);
      req_valid = 1'b1; req_wr = 1'b0;
      req_addr = a; req_len = 8'(len); req_wstrb = 8'($urandom);
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom);
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a);
      chk("arlen", arlen, len);
      chk("arsize", arsize, 3);
      chk("arburst", arburst, 1);
      chk("ar_rready_low", rready, 0);
      for (int i = 0; i < ar_dly; i++) begin
         @(negedge clk);
         chk("arvalid_hold", arvalid, 1);
         chk("araddr_hold", araddr, a);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("ar_drop", arvalid, 0);
      chk("rready", rready, 1);
      for (int b = 0; b <= last_idx; b++) begin
         if (gaps && ($urandom % 3 == 0)) begin
            rvalid = 1'b0;
            #1 chk("rbeat_idle", rbeat_valid, 0);
            @(negedge clk);
         end
         d  = {$urandom, $urandom};
         rr = (b == err_beat) ? 2'($urandom_range(3, 1)) : 2'b00;
         rvalid = 1'b1; rdata = d; rresp = rr; rlast = (b == last_idx);
         #1;
         chk("rbeat_valid", rbeat_valid, 1);
         chk("rbeat_data", rbeat_data, d);
         chk("rbeat_last", rbeat_last, (b == last_idx));
         chk("rd_no_done", done, 0);
         @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      wait_done(exp_err);
   endtask

   // write burst; mode 1 toggles wready 1-0-1-0, mode 0 randomizes it;
   // rst_at >= 0 asserts reset when that many beats have been consumed
   task automatic do_write(input logic [31:0] a, input int len,
                           input int aw_dly, input int b_dly,
                           input logic [1:0] br, input bit mode,
                           input int rst_at);
      logic [63:0] beats[$];
      logic [7:0]  s;
      int          idx = 0;
      int          cyc = 0;
      for (int i = 0; i <= len; i++) beats.push_back({$urandom, $urandom});
      s = 8'($urandom);
      @(negedge clk);
      chk("wr_req_ready", req_ready, 1);
      req_valid = 1'b1; req_wr = 1'b1;
      req_addr = a; req_len = 8'(len); req_wstrb = s;
      wbeat_data = beats[0];
      @(negedge clk);
      req_valid = 1'b0; req_wstrb = ~s; req_addr = $urandom;
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, a);
      chk("awlen", awlen, len);
      chk("awsize", awsize, 3);
      chk("awburst", awburst, 1);
      chk("aw_wvalid_low", wvalid, 0);
      for (int i = 0; i < aw_dly; i++) begin
         @(negedge clk);
         chk("awvalid_hold", awvalid, 1);
         chk("aw_wvalid_hold", wvalid, 0);
      end
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      while (idx <= len && cyc < 8 * (len + 1) + 32) begin
         if (rst_at >= 0 && idx == rst_at) begin
            wready = 1'b0;
            rst = 1'b1;
            #1;
            chk("rst_wvalid", wvalid, 0);
            chk("rst_awvalid", awvalid, 0);
            chk("rst_arvalid", arvalid, 0);
            chk("rst_bready", bready, 0);
            chk("rst_rready", rready, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("post_rst_ready", req_ready, 1);
               chk("post_rst_done", done, 0);
               chk("post_rst_wvalid", wvalid, 0);
            end
            return;
         end
         wready = mode ? (cyc % 2 == 0) : 1'($urandom % 2);
         wbeat_data = beats[idx];
         #1;
         chk("wvalid", wvalid, 1);
         chk("wdata", wdata, beats[idx]);
         chk("wstrb", wstrb, s);
         chk("wlast", wlast, (idx == len));
         chk("wbeat_pop", wbeat_pop, wready);
         @(negedge clk);
         if (wready) idx++;
         cyc++;
      end
      wready = 1'b0;
      if (idx <= len) begin
         chk("w_timeout", 0, 1);
         return;
      end
      chk("w_drop", wvalid, 0);
      chk("bready", bready, 1);
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clk);
         chk("bready_hold", bready, 1);
         chk("b_no_done", done, 0);
      end
      bvalid = 1'b1; bresp = br;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'b00;
      wait_done(br != 2'b00);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
      req_len = '0; req_wstrb = '0; wbeat_data = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
      bvalid = 1'b0; bresp = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("reset_arvalid", arvalid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_awvalid", awvalid, 0);
      chk("reset_wvalid", wvalid, 0);
      chk("reset_bready", bready, 0);
      chk("reset_rready", rready, 0);
      chk("reset_done", done, 0);
      chk("reset_arlen", arlen, 0);

`ifdef AXI_BURST_MASTER_PERF_EN
      do_read(32'h0000_1000, 0, 0, 3, -1, 1'b0);
      chk("perf_rd_bursts", perf_rd_bursts, 1);
      chk("perf_wr_bursts", perf_wr_bursts, 0);
      chk("perf_stall_cyc", perf_stall_cyc, 3);
`endif

      do_read(32'h8000_0000, 7, 7, 0, -1, 1'b0);
      do_write(32'h8000_0040, 3, 0, 2, 2'b00, 1'b1, -1);
      do_read(32'h8000_0100, 3, 1, 0, -1, 1'b0);
      do_write(32'h8000_0200, 0, 1, 0, 2'b10, 1'b0, -1);
      do_write(32'h8000_0300, 7, 0, 0, 2'b00, 1'b0, 2);
      do_read(32'h8000_0400, 3, 5, 1, -1, 1'b0);
      do_read(32'h9000_0000, 255, 255, 0, -1, 1'b0);
      do_write(32'h9000_1000, 255, 0, 0, 2'b00, 1'b0, -1);

      for (int t = 0; t < 40; t++) begin
         int       len, last, eb, ad, bd;
         logic [31:0] a;
         a   = $urandom & 32'hFFFF_FFF8;
         len = ($urandom % 8 == 0) ? 255 : int'($urandom % 16);
         ad  = $urandom % 4;
         bd  = $urandom % 4;
         if ($urandom % 2 == 0) begin
            last = ($urandom % 5 == 0) ? int'($urandom % (len + 3)) : len;
            eb   = ($urandom % 5 == 0) ? int'($urandom % (last + 1)) : -1;
            do_read(a, len, last, ad, eb, 1'($urandom % 2));
         end else begin
            do_write(a, len, ad, bd,
                     ($urandom % 5 == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                     1'b0, -1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 full master that turns one cache-side request (line refill or line writeback) into one INCR burst of 64-bit beats.
- Sits between the data-cache miss/writeback logic and the memory-side AXI slave.
- Handles one outstanding transaction at a time: read or write, never both.
- Returns a single completion pulse with an error flag.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, beat width; arsize/awsize fixed at log2(DATA_W/8) = 3.
- LEN_W, 8, width of the AXI len field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request from the cache.
- req_ready  out  1  request accepted; high only in IDLE.
- req_wr  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  burst start address, 8-byte aligned.
- req_len  in  LEN_W  number of beats minus 1.
- req_wstrb  in  8  byte strobe applied to every W beat.
- wbeat_data  in  DATA_W  current write beat supplied by the cache.
- wbeat_pop  out  1  pulse: current write beat consumed; cache advances its index.
- rbeat_valid  out  1  read beat valid; no backpressure.
- rbeat_data  out  DATA_W  read beat data.
- rbeat_last  out  1  final read beat.
- done  out  1  one-cycle completion pulse.
- done_err  out  1  error flag, valid with done.
- araddr, arvalid, arready, arlen, arsize, arburst: AR channel; master drives all except arready.
- rdata, rresp, rvalid, rlast, rready: R channel; master drives rready.
- awaddr, awvalid, awready, awlen, awsize, awburst: AW channel; master drives all except awready.
- wdata, wstrb, wlast, wvalid, wready: W channel; master drives all except wready.
- bresp, bvalid, bready: B channel; master drives bready.

Behaviour:
- States: IDLE, AR, R, AW, W, B, DONE.
- Reset: state IDLE; all valid, ready and pulse outputs 0; address, len and beat counter 0; error flag 0.
- Reset asserted mid-burst abandons the transaction immediately; no done pulse.
- IDLE: req_ready = 1. On req_valid, latch addr, len, wstrb and wr, clear beat counter and error flag, then go to AW (wr = 1) or AR (wr = 0).
- Burst fields: arburst/awburst = 2'b01 and arsize/awsize = 3'd3 always; arlen/awlen = latched len.
- AR: arvalid = 1 and araddr held stable until arready; go to R.
- R: rready = 1.
  - Each rvalid beat: rbeat_valid = 1, rbeat_data = rdata, combinational, same cycle; beat counter +1.
  - rresp != 2'b00 sets the sticky error flag.
  - rlast with count == len: go to DONE.
  - rlast early (count < len) or missing at count == len: set error; leave R only on rlast.
- AW: awvalid = 1 until awready, then go to W. W is never asserted before the AW handshake.
- W: wvalid = 1, wdata = wbeat_data, wstrb = latched strb, wlast = (count == len).
  - On wvalid & wready: wbeat_pop pulses the same cycle; counter +1.
  - Handshake carrying wlast: go to B.
- B: bready = 1. On bvalid, bresp != 2'b00 sets error; go to DONE.
- DONE: done = 1 and done_err = error flag for exactly one cycle, then IDLE.
- Latency: request to AR/AW valid is 1 cycle; zero-wait slave gives done 2 cycles after the final handshake.
- Counter is LEN_W+1 bits, so len = 255 never wraps.
- len = 0 gives a single beat with wlast/rbeat_last on beat 0.

Optional Feature:
- Macro: AXI_BURST_MASTER_PERF_EN.
- When defined, adds outputs perf_rd_bursts[31:0], perf_wr_bursts[31:0] and perf_stall_cyc[31:0].
- perf_rd_bursts / perf_wr_bursts increment on each DONE of that kind.
- perf_stall_cyc increments each cycle a valid is high without its ready.
- All three reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent; functional behaviour is identical.

Decomposition:
- Package axi_pkg:
  - BURST_INCR = 2'b01; SIZE_8B = 3'd3.
  - RESP_OKAY / EXOKAY / SLVERR / DECERR.
  - State enum for this block.
- Sub-module axi_burst_perf (instantiated only under the macro): counters driven by state, valid and ready.

Test Plan:
- Read, addr 0x8000_0000, len 7, zero-wait slave -> 8 rbeat_valid pulses, rbeat_last on beat 7, done = 1, done_err = 0, arlen = 7, arburst = 01.
- Write, addr 0x8000_0040, len 3, wready toggled 1-0-1-0 -> 4 wbeat_pop pulses aligned to handshakes, wlast only on beat 3, bready until bvalid, done_err = 0.
- Read, len 3, slave asserts rlast on beat 1 -> done_err = 1, return to IDLE.
- Write, len 0, bresp = 2'b10 -> single beat with wlast = 1, done_err = 1.
- Assert rst during W beat 2 of len 7 -> all valids 0 asynchronously, req_ready = 1 after release, no done pulse.
- PERF_EN on: one read with arready delayed 3 cycles -> perf_rd_bursts = 1, perf_stall_cyc = 3.
